// File: rtl/k423_mem_arb_if.sv
// k423 memory arbiter bus: fetch and LSU request/response channels plus the shared memory port.
interface k423_mem_arb_if #(
    parameter int unsigned CORE_ADDR_W  = 32,
    parameter int unsigned CORE_XLEN    = 32,
    parameter int unsigned CORE_FETCH_W = 64
);
    // Fetch channel
    logic                    if_req_vld_i;
    logic                    if_req_wen_i;
    logic [CORE_ADDR_W-1:0]  if_req_addr_i;
    logic [CORE_XLEN-1:0]    if_req_wdata_i;
    logic                    if_req_rdy_o;
    logic                    if_rsp_vld_o;
    logic [CORE_FETCH_W-1:0] if_rsp_rdata_o;
    logic                    if_kill_i;

    // LSU channel
    logic                    ls_req_vld_i;
    logic                    ls_req_wen_i;
    logic [CORE_ADDR_W-1:0]  ls_req_addr_i;
    logic [CORE_XLEN-1:0]    ls_req_wdata_i;
    logic                    ls_req_rdy_o;
    logic                    ls_rsp_vld_o;
    logic [CORE_XLEN-1:0]    ls_rsp_rdata_o;

    // Memory port
    logic                    mem_req_vld_o;
    logic                    mem_req_wen_o;
    logic [CORE_ADDR_W-1:0]  mem_req_addr_o;
    logic [CORE_XLEN-1:0]    mem_req_wdata_o;
    logic                    mem_req_rdy_i;
    logic                    mem_rsp_vld_i;
    logic [CORE_FETCH_W-1:0] mem_rsp_rdata_i;

    // Arbiter side
    modport slave (
        input  if_req_vld_i, if_req_wen_i, if_req_addr_i, if_req_wdata_i, if_kill_i,
        output if_req_rdy_o, if_rsp_vld_o, if_rsp_rdata_o,
        input  ls_req_vld_i, ls_req_wen_i, ls_req_addr_i, ls_req_wdata_i,
        output ls_req_rdy_o, ls_rsp_vld_o, ls_rsp_rdata_o,
        output mem_req_vld_o, mem_req_wen_o, mem_req_addr_o, mem_req_wdata_o,
        input  mem_req_rdy_i, mem_rsp_vld_i, mem_rsp_rdata_i
    );

    // Core + memory side
    modport master (
        output if_req_vld_i, if_req_wen_i, if_req_addr_i, if_req_wdata_i, if_kill_i,
        input  if_req_rdy_o, if_rsp_vld_o, if_rsp_rdata_o,
        output ls_req_vld_i, ls_req_wen_i, ls_req_addr_i, ls_req_wdata_i,
        input  ls_req_rdy_o, ls_rsp_vld_o, ls_rsp_rdata_o,
        input  mem_req_vld_o, mem_req_wen_o, mem_req_addr_o, mem_req_wdata_o,
        output mem_req_rdy_i, mem_rsp_vld_i, mem_rsp_rdata_i
    );
endinterface

// File: rtl/k423_mem_arb.sv
// k423 memory arbiter: LSU-priority grant with fetch starvation guard, grant lock,
// in-order outstanding tracking for response routing, and fetch kill on redirect.
module k423_mem_arb #(
    parameter int unsigned OST_DEPTH  = 4,
    parameter int unsigned STARVE_MAX = 3,
    parameter int unsigned CORE_XLEN  = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    k423_mem_arb_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(OST_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);

    localparam logic [0:0] OWN_IF = 1'b0;
    localparam logic [0:0] OWN_LS = 1'b1;

    logic [OST_DEPTH-1:0] owner_q,  owner_d;
    logic [OST_DEPTH-1:0] killed_q, killed_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     cnt_q,    cnt_d;
    logic                 lock_q,   lock_d;
    logic [0:0]           lock_own_q, lock_own_d;
    logic [STV_W-1:0]     starve_q, starve_d;

    logic       full, empty;
    logic [0:0] gnt_own;
    logic       gnt_vld, req_vld;
    logic       push, pop, if_hs, ls_hs;
    logic [0:0] head_own;
    logic       head_kill;

    // Grant selection, handshakes and response routing (all zero-cycle)
    always_comb begin
        full  = (cnt_q == CNT_W'(OST_DEPTH));
        empty = (cnt_q == '0);

        if (lock_q) begin
            gnt_own = lock_own_q;
        end else if (bus.ls_req_vld_i &&
                     !(bus.if_req_vld_i && (starve_q == STV_W'(STARVE_MAX)))) begin
            gnt_own = OWN_LS;
        end else begin
            gnt_own = OWN_IF;
        end

        gnt_vld = (gnt_own == OWN_LS) ? bus.ls_req_vld_i : bus.if_req_vld_i;
        req_vld = ~rst_i & ~full & gnt_vld;
        push    = req_vld & bus.mem_req_rdy_i;
        if_hs   = push & (gnt_own == OWN_IF);
        ls_hs   = push & (gnt_own == OWN_LS);

        pop       = ~rst_i & bus.mem_rsp_vld_i & ~empty;
        head_own  = owner_q[rd_ptr_q];
        head_kill = killed_q[rd_ptr_q];

        bus.mem_req_vld_o   = req_vld;
        bus.mem_req_wen_o   = (gnt_own == OWN_LS) ? bus.ls_req_wen_i   : bus.if_req_wen_i;
        bus.mem_req_addr_o  = (gnt_own == OWN_LS) ? bus.ls_req_addr_i  : bus.if_req_addr_i;
        bus.mem_req_wdata_o = (gnt_own == OWN_LS) ? bus.ls_req_wdata_i : bus.if_req_wdata_i;
        bus.if_req_rdy_o    = if_hs;
        bus.ls_req_rdy_o    = ls_hs;

        bus.if_rsp_vld_o    = pop & (head_own == OWN_IF) & ~head_kill & ~bus.if_kill_i;
        bus.if_rsp_rdata_o  = bus.mem_rsp_rdata_i;
        bus.ls_rsp_vld_o    = pop & (head_own == OWN_LS);
        bus.ls_rsp_rdata_o  = bus.mem_rsp_rdata_i[CORE_XLEN-1:0];
    end

    // Next state for outstanding FIFO, grant lock and starvation counter
    always_comb begin
        owner_d    = owner_q;
        killed_d   = killed_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        lock_d     = 1'b0;
        lock_own_d = lock_own_q;
        starve_d   = starve_q;

        // Owner bit 0 marks fetch entries; stale slots are rewritten on push
        if (bus.if_kill_i) begin
            killed_d = killed_q | ~owner_q;
        end

        if (push) begin
            owner_d[wr_ptr_q]  = gnt_own;
            killed_d[wr_ptr_q] = (gnt_own == OWN_IF) & bus.if_kill_i;
            wr_ptr_d           = wr_ptr_q + PTR_W'(1);
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase

        if (req_vld && !bus.mem_req_rdy_i) begin
            lock_d     = 1'b1;
            lock_own_d = gnt_own;
        end

        if (if_hs || !bus.if_req_vld_i) begin
            starve_d = '0;
        end else if (ls_hs && (starve_q != STV_W'(STARVE_MAX))) begin
            starve_d = starve_q + STV_W'(1);
        end
    end

    // State registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            owner_q    <= '0;
            killed_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            lock_q     <= 1'b0;
            lock_own_q <= OWN_IF;
            starve_q   <= '0;
        end else begin
            owner_q    <= owner_d;
            killed_q   <= killed_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            lock_q     <= lock_d;
            lock_own_q <= lock_own_d;
            starve_q   <= starve_d;
        end
    end
endmodule

// File: tb/tb_k423_mem_arb.sv
// Scoreboard bench for k423_mem_arb: queue-driven requesters, in-order memory model,
// per-port expected response queues filled when requests are issued.
module tb_k423_mem_arb;
    localparam int unsigned AW = 32;
    localparam int unsigned XW = 32;
    localparam int unsigned FW = 64;

    logic clk = 1'b0;
    logic rst;

    k423_mem_arb_if #(.CORE_ADDR_W(AW), .CORE_XLEN(XW), .CORE_FETCH_W(FW)) bus();

    k423_mem_arb #(.OST_DEPTH(4), .STARVE_MAX(3), .CORE_XLEN(XW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [AW-1:0] if_src_q[$];
    logic [AW-1:0] ls_src_q[$];
    logic [FW-1:0] exp_if_q[$];
    logic [XW-1:0] exp_ls_q[$];
    logic [FW-1:0] mem_pend_q[$];
    bit            exp_grant_q[$];

    logic if_hs_seen = 1'b0;
    logic ls_hs_seen = 1'b0;
    logic rsp_en     = 1'b0;
    logic stray_rsp  = 1'b0;
    logic mem_flush  = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [FW-1:0] mem_data(input logic [AW-1:0] a);
        return {a ^ 32'hA5A5_0000, a + 32'h0000_1234};
    endfunction

    task automatic issue_if(input logic [AW-1:0] a, input bit expect_rsp);
        if_src_q.push_back(a);
        if (expect_rsp) exp_if_q.push_back(mem_data(a));
    endtask

    task automatic issue_ls(input logic [AW-1:0] a, input bit expect_rsp);
        logic [FW-1:0] d;
        d = mem_data(a);
        ls_src_q.push_back(a);
        if (expect_rsp) exp_ls_q.push_back(d[XW-1:0]);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        int pend;
        n = 0;
        pend = 1;
        while (n < budget) begin
            pend = if_src_q.size() + ls_src_q.size() + exp_if_q.size() + exp_ls_q.size()
                 + mem_pend_q.size() + int'(bus.if_req_vld_i) + int'(bus.ls_req_vld_i);
            if (pend == 0) break;
            cyc(1);
            n++;
        end
        check_eq(tag, 64'(pend), 64'(0));
    endtask

    // Fetch requester: holds request until handshake, then loads the next one
    always @(posedge clk) begin
        #1;
        if (if_hs_seen) bus.if_req_vld_i = 1'b0;
        if (!bus.if_req_vld_i && if_src_q.size() > 0) begin
            bus.if_req_addr_i  = if_src_q.pop_front();
            bus.if_req_wdata_i = ~bus.if_req_addr_i;
            bus.if_req_wen_i   = bus.if_req_addr_i[2];
            bus.if_req_vld_i   = 1'b1;
        end
    end

    // LSU requester
    always @(posedge clk) begin
        #1;
        if (ls_hs_seen) bus.ls_req_vld_i = 1'b0;
        if (!bus.ls_req_vld_i && ls_src_q.size() > 0) begin
            bus.ls_req_addr_i  = ls_src_q.pop_front();
            bus.ls_req_wdata_i = ~bus.ls_req_addr_i;
            bus.ls_req_wen_i   = bus.ls_req_addr_i[2];
            bus.ls_req_vld_i   = 1'b1;
        end
    end

    // Memory model: in-order responses, earliest one cycle after acceptance
    always @(posedge clk) begin
        #1;
        if (mem_flush) mem_pend_q.delete();
        if (stray_rsp) begin
            bus.mem_rsp_vld_i   = 1'b1;
            bus.mem_rsp_rdata_i = 64'hDEAD_BEEF_0BAD_F00D;
        end else if (rsp_en && mem_pend_q.size() > 0) begin
            bus.mem_rsp_vld_i   = 1'b1;
            bus.mem_rsp_rdata_i = mem_pend_q.pop_front();
        end else begin
            bus.mem_rsp_vld_i   = 1'b0;
        end
    end

    // Monitor: handshakes, payload, grant order and response scoreboard
    always @(negedge clk) begin
        if_hs_seen = bus.if_req_vld_i & bus.if_req_rdy_o;
        ls_hs_seen = bus.ls_req_vld_i & bus.ls_req_rdy_o;
        if (bus.mem_req_vld_o && bus.mem_req_rdy_i) begin
            mem_pend_q.push_back(mem_data(bus.mem_req_addr_o));
            check_eq("one_rdy", 64'(bus.if_req_rdy_o ^ bus.ls_req_rdy_o), 64'(1));
            check_eq("mem_addr", 64'(bus.mem_req_addr_o),
                     64'(bus.ls_req_rdy_o ? bus.ls_req_addr_i : bus.if_req_addr_i));
            check_eq("mem_wdata", 64'(bus.mem_req_wdata_o), 64'(XW'(~bus.mem_req_addr_o)));
            check_eq("mem_wen", 64'(bus.mem_req_wen_o), 64'(bus.mem_req_addr_o[2]));
            if (exp_grant_q.size() > 0)
                check_eq("grant_is_ls", 64'(bus.ls_req_rdy_o), 64'(exp_grant_q.pop_front()));
        end
        if (bus.if_rsp_vld_o) begin
            if (exp_if_q.size() == 0) check_eq("if_rsp_unexp", 64'(bus.if_rsp_vld_o), 64'(0));
            else check_eq("if_rdata", bus.if_rsp_rdata_o, exp_if_q.pop_front());
        end
        if (bus.ls_rsp_vld_o) begin
            if (exp_ls_q.size() == 0) check_eq("ls_rsp_unexp", 64'(bus.ls_rsp_vld_o), 64'(0));
            else check_eq("ls_rdata", 64'(bus.ls_rsp_rdata_o), 64'(exp_ls_q.pop_front()));
        end
    end

    initial begin
        rst = 1'b1;
        bus.if_req_vld_i = 1'b0; bus.if_req_wen_i = 1'b0; bus.if_req_addr_i = '0; bus.if_req_wdata_i = '0;
        bus.ls_req_vld_i = 1'b0; bus.ls_req_wen_i = 1'b0; bus.ls_req_addr_i = '0; bus.ls_req_wdata_i = '0;
        bus.if_kill_i = 1'b0; bus.mem_req_rdy_i = 1'b0;
        bus.mem_rsp_vld_i = 1'b0; bus.mem_rsp_rdata_i = '0;
        cyc(3);
        check_eq("rst_mem_vld", 64'(bus.mem_req_vld_o), 64'(0));
        check_eq("rst_if_rdy", 64'(bus.if_req_rdy_o), 64'(0));
        check_eq("rst_ls_rdy", 64'(bus.ls_req_rdy_o), 64'(0));
        rst = 1'b0;
        cyc(1);

        // Both requesters busy: LS,LS,LS,IF,LS,LS,LS,IF
        bus.mem_req_rdy_i = 1'b1;
        rsp_en = 1'b1;
        for (int i = 0; i < 6; i++) issue_ls(32'h2000 + 32'(i * 4), 1'b1);
        for (int i = 0; i < 2; i++) issue_if(32'h1000 + 32'(i * 4), 1'b1);
        exp_grant_q = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        wait_idle("t1_drain", 40);
        check_eq("t1_grants_left", 64'(exp_grant_q.size()), 64'(0));

        // Grant lock: fetch stalled 3 cycles keeps grant once LSU arrives
        bus.mem_req_rdy_i = 1'b0;
        exp_grant_q = '{1'b0, 1'b1};
        issue_if(32'h1100, 1'b1);
        cyc(3);
        issue_ls(32'h2100, 1'b1);
        cyc(1);
        check_eq("t2_locked_addr", 64'(bus.mem_req_addr_o), 64'(32'h1100));
        bus.mem_req_rdy_i = 1'b1;
        wait_idle("t2_drain", 20);
        check_eq("t2_grants_left", 64'(exp_grant_q.size()), 64'(0));

        // FIFO full: pop in same cycle still blocks the new request
        rsp_en = 1'b0;
        for (int i = 0; i < 5; i++) issue_ls(32'h3000 + 32'(i * 4), 1'b1);
        cyc(8);
        check_eq("t3_full_rdy", 64'(bus.ls_req_rdy_o), 64'(0));
        check_eq("t3_full_vld", 64'(bus.mem_req_vld_o), 64'(0));
        rsp_en = 1'b1;
        cyc(1);
        check_eq("t3_pop_rsp", 64'(bus.ls_rsp_vld_o), 64'(1));
        check_eq("t3_pop_blk_rdy", 64'(bus.ls_req_rdy_o), 64'(0));
        check_eq("t3_pop_blk_vld", 64'(bus.mem_req_vld_o), 64'(0));
        cyc(1);
        check_eq("t3_next_rdy", 64'(bus.ls_req_rdy_o), 64'(1));
        wait_idle("t3_drain", 20);

        // Kill with two fetches and one LSU in flight
        rsp_en = 1'b0;
        issue_if(32'h1200, 1'b0);
        issue_if(32'h1204, 1'b0);
        cyc(4);
        issue_ls(32'h2200, 1'b1);
        cyc(4);
        bus.if_kill_i = 1'b1;
        cyc(1);
        bus.if_kill_i = 1'b0;
        rsp_en = 1'b1;
        cyc(1);
        check_eq("t4_slot0_ls", 64'(bus.ls_rsp_vld_o), 64'(0));
        check_eq("t4_slot0_if", 64'(bus.if_rsp_vld_o), 64'(0));
        cyc(1);
        check_eq("t4_slot1_ls", 64'(bus.ls_rsp_vld_o), 64'(0));
        check_eq("t4_slot1_if", 64'(bus.if_rsp_vld_o), 64'(0));
        cyc(1);
        check_eq("t4_slot2_ls", 64'(bus.ls_rsp_vld_o), 64'(1));
        check_eq("t4_slot2_if", 64'(bus.if_rsp_vld_o), 64'(0));
        wait_idle("t4_drain", 20);

        // Kill coinciding with a fetch handshake and a fetch-head response
        rsp_en = 1'b0;
        issue_if(32'h1300, 1'b0);
        cyc(4);
        bus.mem_req_rdy_i = 1'b0;
        issue_if(32'h1304, 1'b0);
        cyc(3);
        rsp_en = 1'b1;
        cyc(1);
        bus.mem_req_rdy_i = 1'b1;
        bus.if_kill_i = 1'b1;
        #1;
        check_eq("t5_kill_hs", 64'(bus.if_req_rdy_o), 64'(1));
        check_eq("t5_kill_head", 64'(bus.if_rsp_vld_o), 64'(0));
        cyc(1);
        bus.if_kill_i = 1'b0;
        #1;
        check_eq("t5_killed_push", 64'(bus.if_rsp_vld_o), 64'(0));
        issue_if(32'h1308, 1'b1);
        wait_idle("t5_drain", 20);

        // Reset with three outstanding, stray responses, then fresh traffic
        rsp_en = 1'b0;
        issue_if(32'h1400, 1'b0);
        issue_ls(32'h2400, 1'b0);
        issue_ls(32'h2404, 1'b0);
        cyc(6);
        rsp_en = 1'b1;
        cyc(1);
        rst = 1'b1;
        #1;
        check_eq("t6_rst_ls_rsp", 64'(bus.ls_rsp_vld_o), 64'(0));
        check_eq("t6_rst_if_rsp", 64'(bus.if_rsp_vld_o), 64'(0));
        rsp_en = 1'b0;
        mem_flush = 1'b1;
        stray_rsp = 1'b1;
        cyc(1);
        mem_flush = 1'b0;
        check_eq("t6_stray_ls", 64'(bus.ls_rsp_vld_o), 64'(0));
        check_eq("t6_stray_if", 64'(bus.if_rsp_vld_o), 64'(0));
        issue_ls(32'h2500, 1'b1);
        cyc(1);
        check_eq("t6_rst_ls_rdy", 64'(bus.ls_req_rdy_o), 64'(0));
        check_eq("t6_rst_mem_vld", 64'(bus.mem_req_vld_o), 64'(0));
        rst = 1'b0;
        #1;
        check_eq("t6_post_rdy", 64'(bus.ls_req_rdy_o), 64'(1));
        check_eq("t6_empty_ls", 64'(bus.ls_rsp_vld_o), 64'(0));
        check_eq("t6_empty_if", 64'(bus.if_rsp_vld_o), 64'(0));
        stray_rsp = 1'b0;
        rsp_en = 1'b1;
        issue_if(32'h1500, 1'b1);
        wait_idle("t6_drain", 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
